// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: bus codes, peripheral
// address windows and the AHB slave front-end state encoding.
package bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Three 64 MiB peripheral windows, contiguous from 0x8000_0000
  localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational peripheral decoder: maps an address onto a one-hot select
// and flags whether it falls in any bridge window. Shared with the APB side.
module ahb_addr_decode
  import bridge_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  sel,
  output logic        in_range
);

  // Pick the window containing the address; no window means out of range
  always_comb begin
    sel = 3'b000;
    if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
      sel = 3'b001;
    end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
      sel = 3'b010;
    end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
      sel = 3'b100;
    end
    in_range = |sel;
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge. Qualifies address
// phases, captures one request, holds it on the back-end valid/ready
// handshake with wait states, and returns read data or an ERROR response.
module ahb_slave_if
  import bridge_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic        be_valid,
  output logic        be_write,
  output logic [31:0] be_addr,
  output logic [31:0] be_wdata,
  output logic [2:0]  be_sel,
  input  logic        be_ready,
  input  logic [31:0] be_rdata
);

  // Counter only needs to reach TIMEOUT-1; a stall at that value times out
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic [2:0]       sel;
  logic             in_range;
  logic             accept;
  logic             timeout_hit;
  logic             capture;
  logic             wdata_load;
  logic             rdata_load;

  ahb_addr_decode u_decode (
    .addr     (Haddr),
    .sel      (sel),
    .in_range (in_range)
  );

  assign accept      = Hreadyout && Hreadyin &&
                       (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Ready and response are pure functions of the current state
  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    case (state)
      ST_WDATA, ST_BUSY: Hreadyout = 1'b0;
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = HRESP_ERROR;
      end
      ST_ERR2: Hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Next state, capture strobes and wait-counter update
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    wdata_load    = 1'b0;
    rdata_load    = 1'b0;
    case (state)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (accept && !in_range) begin
          state_next = ST_ERR1;
        end else if (accept) begin
          capture    = 1'b1;
          state_next = Hwrite ? ST_WDATA : ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WDATA: begin
        wdata_load = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        // A completion in the same cycle as the timeout still wins
        if (be_ready) begin
          rdata_load = !be_write;
          state_next = ST_RESP;
        end else if (timeout_hit) begin
          state_next = ST_ERR1;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_BUSY && state != ST_BUSY) begin
      wait_cnt_next = '0;
    end
  end

  // State, wait counter and every registered bus and back-end output
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      be_valid <= 1'b0;
      be_write <= 1'b0;
      be_addr  <= '0;
      be_wdata <= '0;
      be_sel   <= '0;
      Hrdata   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      be_valid <= (state_next == ST_BUSY);
      if (capture) begin
        be_addr  <= Haddr;
        be_write <= Hwrite;
        be_sel   <= sel;
      end
      if (wdata_load) begin
        be_wdata <= Hwdata;
      end
      if (rdata_load) begin
        Hrdata <= be_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: a bus driver records what the slave
// does for each transfer, and per-feature tasks compare it against expected
// results taken from a scoreboard queue filled when the stimulus is issued.
module tb_ahb_slave_if;

  localparam int TIMEOUT = 16;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic        be_valid;
  logic        be_write;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic [2:0]  be_sel;
  logic        be_ready;
  logic [31:0] be_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
    int          vcycles;
    int          first_err;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata = 32'h0;

  // What the driver saw during the most recent transfer
  int          obs_waits, obs_vcycles, obs_first_err;
  logic        obs_ready_a, obs_stable, obs_hung, obs_write;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [2:0]  obs_sel;

  always #5 Hclk = ~Hclk;

  ahb_slave_if #(.TIMEOUT(TIMEOUT)) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hrdata    (Hrdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .be_valid  (be_valid),
    .be_write  (be_write),
    .be_addr   (be_addr),
    .be_wdata  (be_wdata),
    .be_sel    (be_sel),
    .be_ready  (be_ready),
    .be_rdata  (be_rdata)
  );

  // Expected outcome of one transfer, from the bus timing rules
  task automatic push_exp(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                          input logic [31:0] wdata, input int stall, input logic [31:0] brdata);
    exp_t e;
    logic to;
    e.sel = 3'b000;
    if (addr >= 32'h8000_0000 && addr < 32'h8400_0000) e.sel = 3'b001;
    else if (addr >= 32'h8400_0000 && addr < 32'h8800_0000) e.sel = 3'b010;
    else if (addr >= 32'h8800_0000 && addr < 32'h8C00_0000) e.sel = 3'b100;
    e.resp = 2'b00; e.rdata = last_rdata; e.waits = 0; e.vcycles = 0; e.first_err = 0;
    e.addr = addr; e.wdata = wdata;
    if (!trans[1]) begin
      e.sel = 3'b000;
    end else if (e.sel == 3'b000) begin
      e.resp = 2'b01; e.waits = 1; e.first_err = 1;
    end else begin
      to = (stall < 0) || (stall >= TIMEOUT);
      e.vcycles   = to ? TIMEOUT : stall + 1;
      e.waits     = (wr ? 1 : 0) + e.vcycles + (to ? 1 : 0);
      e.first_err = to ? (wr ? 1 : 0) + TIMEOUT + 1 : 0;
      e.resp      = to ? 2'b01 : 2'b00;
      if (!wr && !to) begin
        e.rdata    = brdata;
        last_rdata = brdata;
      end
    end
    sb.push_back(e);
  endtask

  // Drive one address phase now (call at a negedge while Hreadyout=1) and
  // follow it to its completing cycle; back end answers on BUSY cycle 'stall'
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                          input logic [31:0] wdata, input int stall, input logic [31:0] brdata);
    int   c;
    logic done;
    obs_ready_a = Hreadyout;
    obs_waits = 0; obs_vcycles = 0; obs_first_err = 0; obs_stable = 1'b1; obs_hung = 1'b0;
    obs_resp = 2'bxx; obs_rdata = 'x; obs_addr = '0; obs_wdata = '0; obs_sel = '0; obs_write = 1'b0;
    Haddr = addr; Hwrite = wr; Htrans = trans; Hreadyin = 1'b1;
    @(posedge Hclk); #1;
    Htrans = 2'b00; Haddr = 32'h0; Hwrite = 1'b0; Hwdata = wdata;
    c = 1; done = 1'b0;
    while (!done && c <= 100) begin
      @(negedge Hclk);
      if (Hreadyout) begin
        obs_resp = Hresp; obs_rdata = Hrdata; done = 1'b1;
      end else begin
        obs_waits++;
        if (Hresp == 2'b01 && obs_first_err == 0) obs_first_err = c;
        if (be_valid) begin
          if (obs_vcycles == 0) begin
            obs_addr = be_addr; obs_wdata = be_wdata; obs_sel = be_sel; obs_write = be_write;
          end else if (be_addr !== obs_addr || be_wdata !== obs_wdata || be_sel !== obs_sel || be_write !== obs_write) begin
            obs_stable = 1'b0;
          end
          if (obs_vcycles == stall) begin
            be_ready = 1'b1; be_rdata = brdata;
          end
          obs_vcycles++;
        end
        @(posedge Hclk); #1;
        be_ready = 1'b0; be_rdata = 32'h0; Hwdata = ~wdata; c++;
      end
    end
    if (!done) obs_hung = 1'b1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = 32'h0;
    Hwdata = 32'h0; be_ready = 1'b0; be_rdata = 32'h0;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    n_checks++; if (Hreadyout !== 1'b1) $display("FAIL rst_hreadyout: got %b want 1", Hreadyout); else n_pass++;
    n_checks++; if (Hresp !== 2'b00) $display("FAIL rst_hresp: got %b want 00", Hresp); else n_pass++;
    n_checks++; if (Hrdata !== 32'h0) $display("FAIL rst_hrdata: got %h want 0", Hrdata); else n_pass++;
    n_checks++; if (be_valid !== 1'b0) $display("FAIL rst_be_valid: got %b want 0", be_valid); else n_pass++;
    n_checks++; if ({be_write, be_sel} !== 4'b0) $display("FAIL rst_be_ctrl: got %b want 0000", {be_write, be_sel}); else n_pass++;
    n_checks++; if ({be_addr, be_wdata} !== 64'h0) $display("FAIL rst_be_data: got %h want 0", {be_addr, be_wdata}); else n_pass++;
    Hreset = 1'b0;
    @(negedge Hclk);
  endtask

  task automatic test_read();
    exp_t e;
    push_exp(32'h8000_0010, 1'b0, 2'b10, 32'h0, 0, 32'hDEAD_BEEF);
    run_xfer(32'h8000_0010, 1'b0, 2'b10, 32'h0, 0, 32'hDEAD_BEEF);
    e = sb.pop_front();
    n_checks++; if (obs_ready_a !== 1'b1) $display("FAIL read_ready_addr: got %b want 1", obs_ready_a); else n_pass++;
    n_checks++; if (obs_waits !== e.waits) $display("FAIL read_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL read_hrdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
    n_checks++; if (obs_resp !== e.resp) $display("FAIL read_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
    n_checks++; if (obs_sel !== e.sel) $display("FAIL read_sel: got %b want %b", obs_sel, e.sel); else n_pass++;
    n_checks++; if ({obs_write, obs_addr} !== {1'b0, e.addr}) $display("FAIL read_be_req: got %b/%h want 0/%h", obs_write, obs_addr, e.addr); else n_pass++;
  endtask

  task automatic test_write_stall();
    exp_t e;
    push_exp(32'h8400_0004, 1'b1, 2'b10, 32'h0000_1234, 3, 32'h0);
    run_xfer(32'h8400_0004, 1'b1, 2'b10, 32'h0000_1234, 3, 32'h5555_AAAA);
    e = sb.pop_front();
    n_checks++; if (obs_waits !== e.waits) $display("FAIL write_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_vcycles !== e.vcycles) $display("FAIL write_valid_cycles: got %0d want %0d", obs_vcycles, e.vcycles); else n_pass++;
    n_checks++; if (obs_stable !== 1'b1) $display("FAIL write_be_stable: got %b want 1", obs_stable); else n_pass++;
    n_checks++; if (obs_addr !== e.addr) $display("FAIL write_be_addr: got %h want %h", obs_addr, e.addr); else n_pass++;
    n_checks++; if (obs_wdata !== e.wdata) $display("FAIL write_be_wdata: got %h want %h", obs_wdata, e.wdata); else n_pass++;
    n_checks++; if ({obs_write, obs_sel} !== {1'b1, e.sel}) $display("FAIL write_be_ctrl: got %b want %b", {obs_write, obs_sel}, {1'b1, e.sel}); else n_pass++;
    n_checks++; if (obs_resp !== e.resp) $display("FAIL write_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL write_hrdata_hold: got %h want %h", obs_rdata, e.rdata); else n_pass++;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    // A stray back-end ready with nothing pending must be ignored
    be_ready = 1'b1; be_rdata = 32'hBAD0_BAD0;
    @(negedge Hclk);
    be_ready = 1'b0; be_rdata = 32'h0;
    n_checks++; if ({be_valid, Hreadyout} !== 2'b01) $display("FAIL stray_ready_state: got %b want 01", {be_valid, Hreadyout}); else n_pass++;
    n_checks++; if (Hrdata !== last_rdata) $display("FAIL stray_ready_hrdata: got %h want %h", Hrdata, last_rdata); else n_pass++;
    push_exp(32'h9000_0000, 1'b0, 2'b10, 32'h0, 0, 32'h1111_1111);
    run_xfer(32'h9000_0000, 1'b0, 2'b10, 32'h0, 0, 32'h1111_1111);
    e = sb.pop_front();
    n_checks++; if (obs_first_err !== e.first_err) $display("FAIL oor_err1_cycle: got %0d want %0d", obs_first_err, e.first_err); else n_pass++;
    n_checks++; if (obs_waits !== e.waits) $display("FAIL oor_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_resp !== e.resp) $display("FAIL oor_err2_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
    n_checks++; if (obs_vcycles !== e.vcycles) $display("FAIL oor_be_valid: got %0d want %0d", obs_vcycles, e.vcycles); else n_pass++;
  endtask

  task automatic test_decode();
    exp_t        e;
    logic [31:0] rd;
    logic [31:0] addrs [0:7];
    addrs = '{32'h8000_0000, 32'h83FF_FFFC, 32'h8400_0000, 32'h87FF_FFFC,
              32'h8800_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      push_exp(addrs[i], 1'b0, 2'b10, 32'h0, 0, rd);
      run_xfer(addrs[i], 1'b0, 2'b10, 32'h0, 0, rd);
      e = sb.pop_front();
      n_checks++; if (obs_resp !== e.resp) $display("FAIL decode_hresp[%h]: got %b want %b", addrs[i], obs_resp, e.resp); else n_pass++;
      n_checks++; if (obs_rdata !== e.rdata) $display("FAIL decode_hrdata[%h]: got %h want %h", addrs[i], obs_rdata, e.rdata); else n_pass++;
      n_checks++; if (obs_waits !== e.waits) $display("FAIL decode_waits[%h]: got %0d want %0d", addrs[i], obs_waits, e.waits); else n_pass++;
      if (e.vcycles > 0) begin
        n_checks++; if (obs_sel !== e.sel) $display("FAIL decode_sel[%h]: got %b want %b", addrs[i], obs_sel, e.sel); else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    push_exp(32'h8000_0100, 1'b0, 2'b10, 32'h0, -1, 32'h0);
    run_xfer(32'h8000_0100, 1'b0, 2'b10, 32'h0, -1, 32'h0);
    e = sb.pop_front();
    n_checks++; if (obs_first_err !== e.first_err) $display("FAIL to_rd_err_cycle: got %0d want %0d", obs_first_err, e.first_err); else n_pass++;
    n_checks++; if (obs_vcycles !== e.vcycles) $display("FAIL to_rd_valid_cycles: got %0d want %0d", obs_vcycles, e.vcycles); else n_pass++;
    n_checks++; if (obs_resp !== e.resp) $display("FAIL to_rd_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL to_rd_hrdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
    push_exp(32'h8000_0104, 1'b0, 2'b10, 32'h0, TIMEOUT - 1, 32'hC0DE_0016);
    run_xfer(32'h8000_0104, 1'b0, 2'b10, 32'h0, TIMEOUT - 1, 32'hC0DE_0016);
    e = sb.pop_front();
    n_checks++; if (obs_resp !== e.resp) $display("FAIL to_edge_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
    n_checks++; if (obs_waits !== e.waits) $display("FAIL to_edge_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL to_edge_hrdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
    n_checks++; if (obs_first_err !== e.first_err) $display("FAIL to_edge_no_err: got %0d want %0d", obs_first_err, e.first_err); else n_pass++;
    push_exp(32'h8800_0008, 1'b1, 2'b10, 32'hFACE_0001, -1, 32'h0);
    run_xfer(32'h8800_0008, 1'b1, 2'b10, 32'hFACE_0001, -1, 32'h0);
    e = sb.pop_front();
    n_checks++; if (obs_first_err !== e.first_err) $display("FAIL to_wr_err_cycle: got %0d want %0d", obs_first_err, e.first_err); else n_pass++;
    n_checks++; if (obs_resp !== e.resp) $display("FAIL to_wr_hresp: got %b want %b", obs_resp, e.resp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_exp(32'h8800_0000, 1'b1, 2'b10, 32'hA5A5_0001, 0, 32'h0);
    run_xfer(32'h8800_0000, 1'b1, 2'b10, 32'hA5A5_0001, 0, 32'h0);
    e = sb.pop_front();
    n_checks++; if (obs_waits !== e.waits) $display("FAIL b2b_wr_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_wdata !== e.wdata) $display("FAIL b2b_wr_wdata: got %h want %h", obs_wdata, e.wdata); else n_pass++;
    // Second address presented in the RESP cycle of the write
    push_exp(32'h8000_0020, 1'b0, 2'b11, 32'h0, 0, 32'h0BAD_CAFE);
    run_xfer(32'h8000_0020, 1'b0, 2'b11, 32'h0, 0, 32'h0BAD_CAFE);
    e = sb.pop_front();
    n_checks++; if (obs_waits !== e.waits) $display("FAIL b2b_rd_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL b2b_rd_hrdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
    n_checks++; if (obs_sel !== e.sel) $display("FAIL b2b_rd_sel: got %b want %b", obs_sel, e.sel); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      push_exp(32'h8400_0040, 1'b1, 2'b10, 32'h7700_0000 + k, 0, 32'h0);
      run_xfer(32'h8400_0040, 1'b1, 2'b10, 32'h7700_0000 + k, 0, 32'h0);
      e = sb.pop_front();
      n_checks++; if (obs_wdata !== e.wdata) $display("FAIL b2b_pre_wdata[%0d]: got %h want %h", k, obs_wdata, e.wdata); else n_pass++;
      // BUSY then IDLE transfer types in the RESP cycle must be ignored
      push_exp(32'h8000_0030, 1'b0, 2'(1 - k), 32'h0, 0, 32'h3333_3333);
      run_xfer(32'h8000_0030, 1'b0, 2'(1 - k), 32'h0, 0, 32'h3333_3333);
      e = sb.pop_front();
      n_checks++; if (obs_waits !== e.waits) $display("FAIL nocap_waits[%0d]: got %0d want %0d", k, obs_waits, e.waits); else n_pass++;
      n_checks++; if (obs_vcycles !== e.vcycles) $display("FAIL nocap_be_valid[%0d]: got %0d want %0d", k, obs_vcycles, e.vcycles); else n_pass++;
      n_checks++; if (obs_rdata !== e.rdata) $display("FAIL nocap_hrdata[%0d]: got %h want %h", k, obs_rdata, e.rdata); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    Haddr = 32'h8000_0040; Hwrite = 1'b0; Htrans = 2'b10; Hreadyin = 1'b1;
    @(posedge Hclk); #1;
    Htrans = 2'b00; Haddr = 32'h0;
    #3;
    n_checks++; if (be_valid !== 1'b1) $display("FAIL mid_busy_valid: got %b want 1", be_valid); else n_pass++;
    Hreset = 1'b1;
    #1;
    last_rdata = 32'h0;
    n_checks++; if ({Hreadyout, Hresp} !== 3'b100) $display("FAIL mid_rst_bus: got %b want 100", {Hreadyout, Hresp}); else n_pass++;
    n_checks++; if (Hrdata !== 32'h0) $display("FAIL mid_rst_hrdata: got %h want 0", Hrdata); else n_pass++;
    n_checks++; if ({be_valid, be_write, be_sel} !== 5'b0) $display("FAIL mid_rst_be_ctrl: got %b want 00000", {be_valid, be_write, be_sel}); else n_pass++;
    n_checks++; if ({be_addr, be_wdata} !== 64'h0) $display("FAIL mid_rst_be_data: got %h want 0", {be_addr, be_wdata}); else n_pass++;
    @(negedge Hclk);
    Hreset = 1'b0;
    @(negedge Hclk);
    push_exp(32'h8400_0100, 1'b0, 2'b10, 32'h0, 1, 32'h600D_F00D);
    run_xfer(32'h8400_0100, 1'b0, 2'b10, 32'h0, 1, 32'h600D_F00D);
    e = sb.pop_front();
    n_checks++; if (obs_waits !== e.waits) $display("FAIL post_rst_waits: got %0d want %0d", obs_waits, e.waits); else n_pass++;
    n_checks++; if (obs_rdata !== e.rdata) $display("FAIL post_rst_hrdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
    n_checks++; if (obs_sel !== e.sel) $display("FAIL post_rst_sel: got %b want %b", obs_sel, e.sel); else n_pass++;
    n_checks++; if (obs_hung !== 1'b0) $display("FAIL post_rst_done: got %b want 0", obs_hung); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_out_of_range();
    test_decode();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
